trigger_event_arbiter: RTL and testbench
========================================

Name: trigger_event_arbiter

Overview:
Collects completed trigger records (one-cycle interrupt pulse with 16-bit trigger ID and 64-bit cycle stamp) from NUM_CH independent trigger decoders. Each channel gets a one-entry pending holding slot. The block arbitrates round-robin into a shared event FIFO and presents events to the readout/host side on a valid/ready interface. It also drives a busy throttle back toward the trigger source and counts records lost to overflow.

Parameters:
NUM_CH, 2, number of trigger decoder channels (1..8)
DEPTH, 16, event FIFO depth in entries (power of 2, >=2)
BUSY_THRESH, 12, FIFO occupancy at or above which busy asserts (1..DEPTH)

Ports:
sampling_clk  in  1  single system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept new records; 0 = ignore incoming pulses
ch_interrupt  in  NUM_CH  per-channel one-cycle record-complete pulse
ch_trigger_id  in  16*NUM_CH  per-channel ID; channel k at bits [16k+15:16k], valid with pulse
ch_trigger_cycle  in  64*NUM_CH  per-channel cycle stamp; channel k at [64k+63:64k], valid with pulse
ev_valid  out  1  FIFO head holds an event
ev_ready  in  1  consumer accepts head this cycle
ev_channel  out  max(1,clog2(NUM_CH))  source channel of head
ev_trigger_id  out  16  head trigger ID
ev_trigger_cycle  out  64  head cycle stamp
fill_level  out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
busy  out  1  throttle to trigger source
dropped_count  out  16  saturating count of lost records
clear_drops  in  1  synchronous clear of dropped_count

Behaviour:
- Reset (reset_n low, async): pending slots empty, FIFO empty, RR pointer = 0. Outputs: ev_valid=0, fill_level=0, busy=0, dropped_count=0. Event data outputs are 0 (FIFO storage need not be cleared).
- Capture: on an edge where enable=1 and ch_interrupt[k]=1:
  - If slot k is empty, or is being granted this same edge, latch ID and cycle into slot k and mark it full.
  - Otherwise the record is dropped and dropped_count increments.
- enable=0: pulses are ignored and not counted as drops. Already-pending slots still drain.
- Multiple channels may pulse on the same edge. Each channel is handled independently. Drops on one edge add the number of dropped channels, saturating at 0xFFFF.
- Arbitration: at most one grant per cycle, and only when fill_level < DEPTH at cycle start; a same-cycle pop does not free space for a same-cycle push. The grant goes to the first full slot searching from RR pointer upward, wrapping. On grant the FIFO writes {channel, ID, cycle}, the slot empties, and the RR pointer becomes granted+1 mod NUM_CH.
- Latency: pulse sampled at edge N, granted during cycle N+1, written at edge N+1. ev_valid is high after edge N+1 if the FIFO was empty: 2 edges pulse-to-valid.
- FIFO: first-word-fall-through. ev_valid = (fill_level != 0). Head data is stable while ev_valid && !ev_ready. Pop on edge when ev_valid && ev_ready. ev_ready while empty has no effect.
- Simultaneous push and pop: fill_level unchanged and order preserved. Pointers wrap modulo DEPTH.
- busy = (fill_level >= BUSY_THRESH) OR any slot full, registered. It reflects state after each edge, one cycle after the cause.
- dropped_count: clear_drops=1 zeroes it. If clear and drops occur on the same edge, the result equals that edge's drop count.
- Data output ordering: FIFO order equals grant order. No reordering within a channel.

Test Plan:
- Single record: ch0 pulse with ID 0xA5A5 and cycle 0x0000_0001_2345_6789, ev_ready=1 -> ev_valid high exactly 2 edges later with ev_channel=0 and matching ID/cycle. Popped next edge, fill_level returns to 0.
- Simultaneous pulses: ch0 and ch1 pulse on the same edge, RR pointer=0 -> events emerge ch0 then ch1 on consecutive cycles. A repeat with pointer=1 (after a lone ch0 grant) emerges ch1 first.
- Overflow: ev_ready=0, DEPTH=16; ch0 pulses 20 times, 4 cycles apart -> 16 stored, 1 held pending, 3 dropped (dropped_count=3). busy rises the cycle after fill_level reaches 12. After draining, 17 events come out in pulse order.
- Back-to-back on one channel: ch1 pulses on consecutive edges with the FIFO not full -> no drops. Each pulse's grant frees the slot for the next pulse.
- Full with concurrent pop: FIFO full, ev_ready=1, and a slot pending -> pop happens and no push that cycle (fill 16->15). The push follows the next cycle (15->16).
- Async reset mid-stream: reset_n low while 5 entries are queued and a slot is pending -> ev_valid, fill_level, busy, and dropped_count are 0 immediately without a clock edge. After release, the first new pulse produces an event after 2 edges.

Source files
------------

// File: rtl/trigger_event_arbiter.sv
// Collects trigger records from NUM_CH decoders into per-channel holding slots,
// arbitrates them round-robin into a FWFT event FIFO, and tracks busy/drops.
module trigger_event_arbiter #(
  parameter  int NUM_CH      = 2,
  parameter  int DEPTH       = 16,
  parameter  int BUSY_THRESH = 12,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W       = $clog2(DEPTH),
  localparam int ENT_W       = CH_W + 16 + 64
) (
  input  logic                   sampling_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [NUM_CH-1:0]      ch_interrupt,
  input  logic [16*NUM_CH-1:0]   ch_trigger_id,
  input  logic [64*NUM_CH-1:0]   ch_trigger_cycle,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CH_W-1:0]        ev_channel,
  output logic [15:0]            ev_trigger_id,
  output logic [63:0]            ev_trigger_cycle,
  output logic [PTR_W:0]         fill_level,
  output logic                   busy,
  output logic [15:0]            dropped_count,
  input  logic                   clear_drops
);

  logic [NUM_CH-1:0] slot_full;
  logic [15:0]       slot_id  [NUM_CH];
  logic [63:0]       slot_cyc [NUM_CH];

  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   cand;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_vld;
  logic [NUM_CH-1:0] grant_oh;
  logic [NUM_CH-1:0] capture;
  logic [NUM_CH-1:0] drop;
  logic [3:0]        drop_n;
  logic [16:0]       drop_sum;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Grant only when the FIFO had room at cycle start; a same-cycle pop does not count.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    grant_oh  = '0;
    cand      = '0;
    if (fill_level < (PTR_W+1)'(DEPTH)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
        if (!grant_vld && slot_full[cand]) begin
          grant_vld = 1'b1;
          grant_ch  = cand;
        end
      end
    end
    if (grant_vld) grant_oh[grant_ch] = 1'b1;
  end

  // A slot being granted this edge can take a new record on the same edge.
  always_comb begin
    capture = '0;
    drop    = '0;
    drop_n  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      capture[k] = enable && ch_interrupt[k] && (!slot_full[k] || grant_oh[k]);
      drop[k]    = enable && ch_interrupt[k] && slot_full[k] && !grant_oh[k];
      drop_n     = drop_n + {3'b000, drop[k]};
    end
    drop_sum = {1'b0, dropped_count} + {13'b0, drop_n};
  end

  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_full <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        slot_id[k]  <= '0;
        slot_cyc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (capture[k]) begin
          slot_full[k] <= 1'b1;
          slot_id[k]   <= ch_trigger_id[16*k +: 16];
          slot_cyc[k]  <= ch_trigger_cycle[64*k +: 64];
        end else if (grant_oh[k]) begin
          slot_full[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_ch == CH_W'(NUM_CH-1)) ? '0 : grant_ch + 1'b1;
    end
  end

  assign push = grant_vld;
  assign pop  = ev_valid && ev_ready;

  always_ff @(posedge sampling_clk) begin
    if (push) mem[wr_ptr] <= {grant_ch, slot_id[grant_ch], slot_cyc[grant_ch]};
  end

  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
    end
  end

  // Data outputs are gated so they read 0 whenever the FIFO is empty.
  assign ev_valid         = (fill_level != '0);
  assign head             = mem[rd_ptr];
  assign ev_channel       = ev_valid ? head[ENT_W-1 -: CH_W] : '0;
  assign ev_trigger_id    = ev_valid ? head[79:64] : '0;
  assign ev_trigger_cycle = ev_valid ? head[63:0]  : '0;

  // busy samples the state left by the previous edge, so it trails its cause by a cycle.
  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (fill_level >= (PTR_W+1)'(BUSY_THRESH)) || (|slot_full);
    end
  end

  always_ff @(posedge sampling_clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_count <= '0;
    end else if (clear_drops) begin
      dropped_count <= {12'b0, drop_n};
    end else if (drop_sum[16]) begin
      dropped_count <= 16'hFFFF;
    end else begin
      dropped_count <= drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_trigger_event_arbiter.sv
// Directed bench for trigger_event_arbiter with the default NUM_CH=2, DEPTH=16, BUSY_THRESH=12.
module tb_trigger_event_arbiter;

  logic          sampling_clk;
  logic          reset_n;
  logic          enable;
  logic [1:0]    ch_interrupt;
  logic [31:0]   ch_trigger_id;
  logic [127:0]  ch_trigger_cycle;
  logic          ev_valid;
  logic          ev_ready;
  logic [0:0]    ev_channel;
  logic [15:0]   ev_trigger_id;
  logic [63:0]   ev_trigger_cycle;
  logic [4:0]    fill_level;
  logic          busy;
  logic [15:0]   dropped_count;
  logic          clear_drops;

  int n_pass = 0;
  int n_total = 0;

  trigger_event_arbiter dut (
    .sampling_clk    (sampling_clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .ch_interrupt    (ch_interrupt),
    .ch_trigger_id   (ch_trigger_id),
    .ch_trigger_cycle(ch_trigger_cycle),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_channel      (ev_channel),
    .ev_trigger_id   (ev_trigger_id),
    .ev_trigger_cycle(ev_trigger_cycle),
    .fill_level      (fill_level),
    .busy            (busy),
    .dropped_count   (dropped_count),
    .clear_drops     (clear_drops)
  );

  initial sampling_clk = 1'b0;
  always #5 sampling_clk = ~sampling_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge sampling_clk);
    #1;
  endtask

  task automatic pulse(input int k, input logic [15:0] id, input logic [63:0] cyc);
    ch_interrupt[k] = 1'b1;
    ch_trigger_id[16*k +: 16] = id;
    ch_trigger_cycle[64*k +: 64] = cyc;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b1;
    ch_interrupt = '0;
    ch_trigger_id = '0;
    ch_trigger_cycle = '0;
    ev_ready = 1'b1;
    clear_drops = 1'b0;
    #12;
    chk("rst_valid", ev_valid, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", dropped_count, 0);
    chk("rst_id", ev_trigger_id, 0);
    chk("rst_cycle", ev_trigger_cycle, 0);
    reset_n = 1'b1;
    step();

    // single record: valid two edges after the pulse
    pulse(0, 16'hA5A5, 64'h0000_0001_2345_6789);
    step();
    ch_interrupt = '0;
    chk("single_not_yet", ev_valid, 0);
    step();
    chk("single_valid", ev_valid, 1);
    chk("single_ch", ev_channel, 0);
    chk("single_id", ev_trigger_id, 16'hA5A5);
    chk("single_cycle", ev_trigger_cycle, 64'h0000_0001_2345_6789);
    chk("single_fill", fill_level, 1);
    chk("single_busy_slot", busy, 1);
    step();
    chk("single_popped", fill_level, 0);
    chk("single_busy_clr", busy, 0);

    // simultaneous pulses with rr pointer at 1 -> ch1 first
    pulse(0, 16'h1111, 64'h11);
    pulse(1, 16'h2222, 64'h22);
    step();
    ch_interrupt = '0;
    step();
    chk("sim1_first_ch", ev_channel, 1);
    chk("sim1_first_id", ev_trigger_id, 16'h2222);
    step();
    chk("sim1_second_ch", ev_channel, 0);
    chk("sim1_second_id", ev_trigger_id, 16'h1111);
    chk("sim1_fill", fill_level, 1);
    step();
    chk("sim1_empty", ev_valid, 0);

    // lone ch1 grant moves pointer to 0
    pulse(1, 16'h3333, 64'h33);
    step();
    ch_interrupt = '0;
    step();
    chk("lone_ch1", ev_channel, 1);
    step();

    // simultaneous pulses with rr pointer at 0 -> ch0 first
    pulse(0, 16'h4444, 64'h44);
    pulse(1, 16'h5555, 64'h55);
    step();
    ch_interrupt = '0;
    step();
    chk("sim0_first_id", ev_trigger_id, 16'h4444);
    step();
    chk("sim0_second_id", ev_trigger_id, 16'h5555);
    chk("sim0_second_ch", ev_channel, 1);
    step();
    chk("sim0_empty", ev_valid, 0);

    // back-to-back pulses on ch1
    for (int i = 1; i <= 3; i++) begin
      pulse(1, 16'h0B00 + 16'(i), 64'hB00 + 64'(i));
      step();
      if (i > 1) chk("b2b_head", ev_trigger_id, 16'h0B00 + 16'(i - 1));
    end
    ch_interrupt = '0;
    step();
    chk("b2b_last", ev_trigger_id, 16'h0B03);
    step();
    chk("b2b_empty", ev_valid, 0);
    chk("b2b_drops", dropped_count, 0);

    // overflow: 20 pulses on ch0, 4 cycles apart, consumer stalled
    ev_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pulse(0, 16'h0C00 + 16'(i), 64'h100 + 64'(i));
      step();
      ch_interrupt = '0;
      step();
      step();
      step();
      chk("ovf_fill", fill_level, (i + 1 > 16) ? 16 : i + 1);
      chk("ovf_busy", busy, (i >= 11) ? 1 : 0);
    end
    chk("ovf_drops", dropped_count, 3);
    chk("ovf_head", ev_trigger_id, 16'h0C00);

    // full FIFO with a pending slot: pop without push, then push
    ev_ready = 1'b1;
    step();
    ev_ready = 1'b0;
    chk("full_pop_fill", fill_level, 15);
    chk("full_pop_head", ev_trigger_id, 16'h0C01);
    step();
    chk("full_push_fill", fill_level, 16);

    ev_ready = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      chk("drain_id", ev_trigger_id, 16'h0C00 + 16'(j));
      chk("drain_cycle", ev_trigger_cycle, 64'h100 + 64'(j));
      step();
    end
    chk("drain_empty", ev_valid, 0);
    chk("drain_fill", fill_level, 0);

    // clear coinciding with a drop leaves that edge's drop count
    pulse(0, 16'h0E00, 64'hE0);
    pulse(1, 16'h0E01, 64'hE1);
    step();
    pulse(0, 16'h0E02, 64'hE2);
    pulse(1, 16'h0E03, 64'hE3);
    clear_drops = 1'b1;
    step();
    ch_interrupt = '0;
    clear_drops = 1'b0;
    chk("clr_drops", dropped_count, 1);
    chk("clr_head0", ev_trigger_id, 16'h0E01);
    step();
    chk("clr_head1", ev_trigger_id, 16'h0E00);
    step();
    chk("clr_head2", ev_trigger_id, 16'h0E03);
    step();
    chk("clr_empty", ev_valid, 0);

    // enable low: pulses ignored, no drops counted
    enable = 1'b0;
    pulse(0, 16'h0F00, 64'hF0);
    step();
    pulse(0, 16'h0F01, 64'hF1);
    step();
    ch_interrupt = '0;
    step();
    step();
    chk("dis_valid", ev_valid, 0);
    chk("dis_drops", dropped_count, 1);
    chk("dis_busy", busy, 0);
    enable = 1'b1;

    // async reset with 5 queued and one slot pending
    ev_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      pulse(0, 16'h0D00, 64'hD0);
      pulse(1, 16'h0D01, 64'hD1);
      step();
      ch_interrupt = '0;
      step();
      step();
    end
    pulse(0, 16'h0D02, 64'hD2);
    pulse(1, 16'h0D03, 64'hD3);
    step();
    ch_interrupt = '0;
    step();
    chk("pre_rst_fill", fill_level, 5);
    chk("pre_rst_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", ev_valid, 0);
    chk("arst_fill", fill_level, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drops", dropped_count, 0);
    #1;
    reset_n = 1'b1;
    ev_ready = 1'b1;
    step();
    pulse(1, 16'h0A0A, 64'hAA);
    step();
    ch_interrupt = '0;
    chk("post_rst_not_yet", ev_valid, 0);
    step();
    chk("post_rst_valid", ev_valid, 1);
    chk("post_rst_ch", ev_channel, 1);
    chk("post_rst_id", ev_trigger_id, 16'h0A0A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
